// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer arbiter: state encoding,
// default sizes and the counter terminal-count helper.
package interval_timer_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_W    = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    E_IDLE = ST_IDLE,
    E_LOAD = ST_LOAD,
    E_RUN  = ST_RUN,
    E_DONE = ST_DONE
  } state_e;

  // All-ones value of a w-bit counter (w up to 31)
  function automatic int unsigned term_count(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/interval_counter.sv
// Shared W-bit loadable up-counter; priority rst > ld > inc, otherwise holds.
module interval_counter
  import interval_timer_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)      r_q <= '0;
    else if (ld)  r_q <= din;
    else if (inc) r_q <= r_q + W'(1);
  end

  assign q = r_q;

endmodule

// File: rtl/interval_timer_arbiter.sv
// Arbitrates requesters onto one shared interval counter and pulses done on expiry.
// CNT_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise fixed priority.
module interval_timer_arbiter
  import interval_timer_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned W    = DEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      cnt
);

  localparam int unsigned SELW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [W-1:0] TERM = W'(term_count(W));

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] w_sel_nxt;
  logic [SELW-1:0] w_win;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_busy;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [NREQ-1:0] w_done_nxt;
  logic            w_busy_nxt;
  logic            w_ld;
  logic            w_inc;
  logic [W-1:0]    w_len_sel;
  logic [W-1:0]    w_cnt;

`ifdef CNT_ARB_ROUND_ROBIN_EN
  logic [SELW-1:0] r_ptr;

  // Pointer remembers the last served requester; reset value makes 0 first
  always_ff @(posedge clk) begin
    if (rst)                    r_ptr <= SELW'(NREQ - 1);
    else if (r_state == ST_DONE) r_ptr <= r_sel;
  end

  always_comb begin
    logic        found;
    int unsigned idx;
    found = 1'b0;
    idx   = 0;
    w_win = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(r_ptr) + k) % NREQ;
      if (!found && req[SELW'(idx)]) begin
        found = 1'b1;
        w_win = SELW'(idx);
      end
    end
  end
`else
  // Fixed priority: lowest set index wins
  always_comb begin
    logic found;
    found = 1'b0;
    w_win = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        w_win = SELW'(i);
      end
    end
  end
`endif

  assign w_len_sel = len[r_sel*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next state, counter controls and next registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ld        = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_sel_nxt   = w_win;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ld        = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_cnt == TERM) w_state_nxt = ST_DONE;
        else               w_inc       = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_gnt_nxt  = '0;
    w_done_nxt = '0;
    if (w_state_nxt == ST_LOAD || w_state_nxt == ST_RUN)
      w_gnt_nxt = NREQ'(1) << w_sel_nxt;
    if (w_state_nxt == ST_DONE)
      w_done_nxt = NREQ'(1) << w_sel_nxt;
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  interval_counter #(.W(W)) u_counter (
    .clk (clk),
    .rst (rst),
    .ld  (w_ld),
    .inc (w_inc),
    .din (~w_len_sel),
    .q   (w_cnt)
  );

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = r_busy;
  assign cnt  = w_cnt;

endmodule
